mackerel_bus_ctrl: RTL and testbench
====================================

# mackerel_bus_ctrl

Bus-cycle terminator that sits directly downstream of the Mackerel address decoder. It consumes the decoder's active-low chip selects and IACK together with the 68000 address strobe. It produces the CPU's DTACK with per-region wait states, and optionally BERR on bus timeout. It replaces the purely combinational DTACK path so that ROM, SRAM, MFP and interrupt-acknowledge cycles terminate with deterministic, cycle-exact timing.

## Interface
- ROM_WS, 2, wait-state cycles inserted before DTACK for ROM cycles (0..15)
- RAM_WS, 0, wait-state cycles for RAMEN0/RAMEN1 cycles (0..15)
- TIMEOUT_CYCLES, 255, edges with AS low and no DTACK before BERR asserts (1..255)
- CLK  in  1  CPU clock; CPU and block share this clock, no synchronisers
- RST  in  1  synchronous, active-low reset
- AS  in  1  CPU address strobe, active-low
- ROMEN  in  1  ROM select from decoder, active-low
- RAMEN0  in  1  SRAM bank 0 select, active-low
- RAMEN1  in  1  SRAM bank 1 select, active-low
- MFPEN  in  1  MFP select, active-low
- IACK  in  1  interrupt-acknowledge cycle, active-low
- DTACK_MFP  in  1  MFP data acknowledge, active-low
- DTACK  out  1  data acknowledge to CPU, active-low, registered
- BERR  out  1  bus error to CPU, active-low, registered; held high when timeout disabled
- TIMEOUT_FLAG  out  1  sticky, high once any timeout has occurred

## Operation
- States: IDLE, WAIT, PASS, ACK, FAULT.
- IDLE: the first edge E0 at which AS is sampled low classifies the cycle. Select priority: IACK, then MFPEN, then ROMEN, then RAMEN0/RAMEN1.
- IACK or MFP cycle: go to PASS.
- ROM or RAM cycle with WS=0: go to ACK.
- ROM or RAM cycle with WS=N>0: go to WAIT, loading count=N.
- No select low: stay in WAIT with no count loaded. This is an unmapped cycle.
- WAIT: decrement count each edge; on the edge where count==1, go to ACK.
- PASS: DTACK is DTACK_MFP registered every edge. DTACK_MFP sampled low marks the cycle acknowledged.
- ACK: DTACK low; hold until AS is sampled high.
- FAULT: BERR low, DTACK high; hold until AS is sampled high.
- Any state, AS sampled high: go to IDLE on that edge; DTACK and BERR go high after that edge. This covers completion and abort alike.
- Selects change mid-cycle: ignored after E0; the cycle class is latched at E0.
- Multiple selects low: the priority above applies and there is no error.

## Timing
- Reset (RST low at an edge): state IDLE, DTACK=1, BERR=1, TIMEOUT_FLAG=0, counters 0.
- ROM/RAM latency: DTACK low after edge E0+WS. With WS=0, DTACK is low in the cycle following E0.
- PASS latency: DTACK follows DTACK_MFP with one CLK of delay.
- Deassert: DTACK/BERR high one CLK after AS is sampled high.
- Back-to-back cycles: IDLE is re-entered on the AS-high edge, so the next AS-low edge is a new E0.

## Configuration
- MACKEREL_BUS_TIMEOUT_EN defined:
  - An 8-bit watchdog counts every edge from E0 while AS is low and DTACK is high.
  - At count==TIMEOUT_CYCLES, go to FAULT and set TIMEOUT_FLAG.
  - If DTACK would assert on the same edge, ACK wins and there is no fault.
- MACKEREL_BUS_TIMEOUT_EN undefined:
  - No watchdog is present; BERR is tied to 1 and TIMEOUT_FLAG to 0.
  - Unmapped cycles, and MFP cycles that never see DTACK_MFP, hang indefinitely.

## Structure
- Package mackerel_bus_pkg contains:
  - the state enum (IDLE/WAIT/PASS/ACK/FAULT)
  - the cycle-class enum (NONE/IACK/MFP/ROM/RAM)
  - the wait-state count width (4) and watchdog width (8)
- Sub-module mackerel_bus_watchdog: the timeout counter with start, clear and expired signals, instantiated only under MACKEREL_BUS_TIMEOUT_EN.

## Test plan
- Reset behaviour: hold RST low 3 cycles with AS toggling -> DTACK=1, BERR=1, TIMEOUT_FLAG=0 throughout.
- RAM cycle: RAMEN0=0, AS low at E0, RAM_WS=0 -> DTACK low after E0. Raise AS -> DTACK high one CLK later.
- ROM cycle: ROMEN=0, ROM_WS=2 -> DTACK low after E0+2. Repeat with ROM_WS=5 -> E0+5.
- MFP cycle: MFPEN=0, DTACK_MFP low 4 cycles after E0 -> DTACK low 5 cycles after E0. Repeat the same stimulus with IACK=0 -> identical timing.
- Abort: ROM_WS=5, AS raised at E0+2 -> DTACK never asserts and the state returns to IDLE. The next cycle is timed from its own E0.
- Timeout, with macro defined and TIMEOUT_CYCLES=16:
  - Unmapped cycle -> BERR low after E0+16 and TIMEOUT_FLAG=1.
  - BERR high one CLK after AS rises; TIMEOUT_FLAG stays 1 until reset.
  - With the macro undefined, the same stimulus gives BERR=1 permanently.

Source files
------------

// File: rtl/mackerel_bus_pkg.sv
// mackerel_bus_pkg: shared types and widths for the Mackerel bus-cycle terminator.
package mackerel_bus_pkg;
   localparam int WS_W = 4;
   localparam int WD_W = 8;
   typedef enum logic [2:0] {IDLE, WAIT, PASS, ACK, FAULT} state_t;
   typedef enum logic [2:0] {CLS_NONE, CLS_IACK, CLS_MFP, CLS_ROM, CLS_RAM} cls_t;
   function automatic cls_t classify(input logic iack, input logic mfpen, input logic romen,
                                     input logic ramen0, input logic ramen1);
      return !iack ? CLS_IACK : !mfpen ? CLS_MFP : !romen ? CLS_ROM :
             (!ramen0 || !ramen1) ? CLS_RAM : CLS_NONE;
   endfunction
endpackage

// File: rtl/mackerel_bus_watchdog.sv
// mackerel_bus_watchdog: counts edges of a bus cycle from E0, flagging expiry at LIMIT.
module mackerel_bus_watchdog
   import mackerel_bus_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic start,
   input  logic clear,
   output logic expired
);
   logic [WD_W-1:0] cnt;
   // E0 itself counts as the first edge; the count saturates instead of wrapping
   always_ff @(posedge CLK)
      if (!RST || clear) cnt <= '0;
      else if (start) cnt <= WD_W'(1);
      else if (cnt != '0 && cnt != '1) cnt <= cnt + WD_W'(1);
   assign expired = cnt == WD_W'(LIMIT);
endmodule

// File: rtl/mackerel_bus_ctrl.sv
// mackerel_bus_ctrl: 68000 bus-cycle terminator driving DTACK with per-region wait states.
// Define MACKEREL_BUS_TIMEOUT_EN to add the BERR watchdog and sticky TIMEOUT_FLAG.
module mackerel_bus_ctrl
   import mackerel_bus_pkg::*;
#(
   parameter int ROM_WS         = 2,
   parameter int RAM_WS         = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic AS,
   input  logic ROMEN,
   input  logic RAMEN0,
   input  logic RAMEN1,
   input  logic MFPEN,
   input  logic IACK,
   input  logic DTACK_MFP,
   output logic DTACK,
   output logic BERR,
   output logic TIMEOUT_FLAG
);
   state_t          state;
   cls_t            cls;
   logic [WS_W-1:0] cnt;
   logic [WS_W-1:0] ws;
   logic            expired;
   assign cls = classify(IACK, MFPEN, ROMEN, RAMEN0, RAMEN1);
   assign ws  = (cls == CLS_ROM) ? WS_W'(ROM_WS) : WS_W'(RAM_WS);
`ifdef MACKEREL_BUS_TIMEOUT_EN
   mackerel_bus_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
      .CLK     (CLK),
      .RST     (RST),
      .start   (state == IDLE && !AS),
      .clear   (AS),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif
   // Acknowledge is tested before expiry so a same-edge DTACK beats the timeout
   always_ff @(posedge CLK)
      if (!RST) begin
         state        <= IDLE;
         cnt          <= '0;
         DTACK        <= 1'b1;
         BERR         <= 1'b1;
         TIMEOUT_FLAG <= 1'b0;
      end else if (AS) begin
         state <= IDLE;
         cnt   <= '0;
         DTACK <= 1'b1;
         BERR  <= 1'b1;
      end else
         case (state)
            IDLE:
               if (cls == CLS_IACK || cls == CLS_MFP) state <= PASS;
               else if (cls == CLS_NONE) state <= WAIT;
               else if (ws == '0) begin
                  state <= ACK;
                  DTACK <= 1'b0;
               end else begin
                  state <= WAIT;
                  cnt   <= ws;
               end
            WAIT:
               if (cnt == WS_W'(1)) begin
                  state <= ACK;
                  DTACK <= 1'b0;
                  cnt   <= '0;
               end else if (expired) begin
                  state        <= FAULT;
                  BERR         <= 1'b0;
                  TIMEOUT_FLAG <= 1'b1;
               end else if (cnt != '0) cnt <= cnt - WS_W'(1);
            PASS:
               if (!DTACK_MFP) begin
                  state <= ACK;
                  DTACK <= 1'b0;
               end else if (expired) begin
                  state        <= FAULT;
                  BERR         <= 1'b0;
                  TIMEOUT_FLAG <= 1'b1;
               end
            default: ;
         endcase
endmodule

// File: tb/tb_mackerel_bus_ctrl.sv
// tb_mackerel_bus_ctrl: randomized and directed checks of two differently configured
// bus controllers against an elapsed-edge model of bus-cycle termination.
module tb_mackerel_bus_ctrl;
`ifdef MACKEREL_BUS_TIMEOUT_EN
   localparam bit TO = 1'b1;
`else
   localparam bit TO = 1'b0;
`endif
   localparam logic [4:0] S_RAM = 5'b11110, S_ROM = 5'b11011, S_MFP = 5'b10111,
                          S_IACK = 5'b01111, S_NONE = 5'b11111;
   logic clk = 1'b0, rst = 1'b0, as_n = 1'b1, dtack_mfp = 1'b1, chk_en = 1'b0;
   logic [4:0] sel = 5'b11111;
   logic dtack_a, berr_a, flag_a, dtack_b, berr_b, flag_b;
   int tests = 0, fails = 0;
   int m_rom[2] = '{2, 5};
   int m_ram[2] = '{0, 7};
   int m_to[2]  = '{16, 7};
   int m_k[2], m_ws[2];
   bit m_act[2], m_pass[2], m_acked[2], m_fault[2];
   logic e_dtack[2] = '{1'b1, 1'b1};
   logic e_berr[2]  = '{1'b1, 1'b1};
   logic e_flag[2]  = '{1'b0, 1'b0};
   always #5 clk = ~clk;
   mackerel_bus_ctrl #(.ROM_WS(2), .RAM_WS(0), .TIMEOUT_CYCLES(16)) dut_a (
      .CLK(clk), .RST(rst), .AS(as_n), .ROMEN(sel[2]), .RAMEN0(sel[0]), .RAMEN1(sel[1]),
      .MFPEN(sel[3]), .IACK(sel[4]), .DTACK_MFP(dtack_mfp),
      .DTACK(dtack_a), .BERR(berr_a), .TIMEOUT_FLAG(flag_a));
   mackerel_bus_ctrl #(.ROM_WS(5), .RAM_WS(7), .TIMEOUT_CYCLES(7)) dut_b (
      .CLK(clk), .RST(rst), .AS(as_n), .ROMEN(sel[2]), .RAMEN0(sel[0]), .RAMEN1(sel[1]),
      .MFPEN(sel[3]), .IACK(sel[4]), .DTACK_MFP(dtack_mfp),
      .DTACK(dtack_b), .BERR(berr_b), .TIMEOUT_FLAG(flag_b));
   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Model: a cycle is judged purely by how many edges have elapsed since its E0
   always @(posedge clk)
      for (int m = 0; m < 2; m++)
         if (!rst) begin
            m_act[m] = 0; e_dtack[m] = 1; e_berr[m] = 1; e_flag[m] = 0;
         end else if (as_n) begin
            m_act[m] = 0; e_dtack[m] = 1; e_berr[m] = 1;
         end else if (!m_act[m]) begin
            m_act[m] = 1; m_k[m] = 0; m_acked[m] = 0; m_fault[m] = 0;
            m_pass[m] = !sel[4] || !sel[3];
            m_ws[m] = m_pass[m] ? -1 : !sel[2] ? m_rom[m] : (!sel[0] || !sel[1]) ? m_ram[m] : -1;
            if (m_ws[m] == 0) begin m_acked[m] = 1; e_dtack[m] = 0; end
         end else if (!m_acked[m] && !m_fault[m]) begin
            m_k[m]++;
            if ((m_pass[m] && !dtack_mfp) || (m_ws[m] > 0 && m_k[m] == m_ws[m])) begin
               m_acked[m] = 1; e_dtack[m] = 0;
            end else if (TO && m_k[m] == m_to[m]) begin
               m_fault[m] = 1; e_berr[m] = 0; e_flag[m] = 1;
            end
         end
   always @(negedge clk)
      if (chk_en) begin
         check("model dtack_a", dtack_a, e_dtack[0]);
         check("model berr_a", berr_a, e_berr[0]);
         check("model flag_a", flag_a, e_flag[0]);
         check("model dtack_b", dtack_b, e_dtack[1]);
         check("model berr_b", berr_b, e_berr[1]);
         check("model flag_b", flag_b, e_flag[1]);
      end
   // Called at a negedge; latencies are edges after E0 at which each output first went low
   task automatic bus_cycle(input logic [4:0] s, input int len, input int mfp_at, input bit jitter,
                            output int la, output int lb, output int ea, output int eb);
      sel = s; as_n = 0; dtack_mfp = 1;
      la = -1; lb = -1; ea = -1; eb = -1;
      for (int i = 0; i < len; i++) begin
         @(posedge clk); @(negedge clk);
         if (!dtack_a && la < 0) la = i;
         if (!dtack_b && lb < 0) lb = i;
         if (!berr_a && ea < 0) ea = i;
         if (!berr_b && eb < 0) eb = i;
         if (i == mfp_at) dtack_mfp = 0;
         if (jitter && $urandom_range(3) == 0) sel = 5'($urandom);
      end
      as_n = 1; sel = S_NONE; dtack_mfp = 1;
      @(posedge clk); @(negedge clk);
   endtask
   initial begin
      int la, lb, ea, eb;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk_en = 1;
         as_n = i[0];
         check("reset dtack", dtack_a, 1);
         check("reset berr", berr_a, 1);
         check("reset flag", flag_a, 0);
      end
      rst = 1; as_n = 1;
      @(posedge clk); @(negedge clk);
      bus_cycle(S_RAM, 10, -1, 0, la, lb, ea, eb);
      check("ram ws0 latency", la, 0);
      check("ram ws7=timeout latency", lb, 7);
      check("ram ws7 no berr", eb, -1);
      check("ram deassert", dtack_a, 1);
      bus_cycle(S_ROM, 8, -1, 0, la, lb, ea, eb);
      check("rom ws2 latency", la, 2);
      check("rom ws5 latency", lb, 5);
      bus_cycle(S_MFP, 8, 4, 0, la, lb, ea, eb);
      check("mfp latency", la, 5);
      check("mfp latency b", lb, 5);
      bus_cycle(S_IACK, 8, 4, 0, la, lb, ea, eb);
      check("iack latency", la, 5);
      bus_cycle(S_ROM, 2, -1, 0, la, lb, ea, eb);
      check("abort rom ws2", la, -1);
      check("abort rom ws5", lb, -1);
      bus_cycle(S_ROM, 8, -1, 0, la, lb, ea, eb);
      check("after abort latency", lb, 5);
      bus_cycle(S_NONE, 20, -1, 0, la, lb, ea, eb);
      check("unmapped no dtack", la, -1);
      check("unmapped berr a", ea, TO ? 16 : -1);
      check("unmapped berr b", eb, TO ? 7 : -1);
      check("berr released", berr_a, 1);
      bus_cycle(S_RAM, 3, -1, 0, la, lb, ea, eb);
      check("flag sticky", flag_a, TO);
      bus_cycle(5'b10010, 6, 2, 0, la, lb, ea, eb);
      check("priority mfp over rom", la, 3);
      bus_cycle(5'b01011, 6, -1, 0, la, lb, ea, eb);
      check("priority iack over rom", la, -1);
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(40) == 0) begin
            rst = 0;
            @(posedge clk); @(negedge clk);
            rst = 1;
         end
         bus_cycle(5'($urandom), $urandom_range(1, 20),
                   $urandom_range(1) ? int'($urandom_range(0, 15)) : -1, 1, la, lb, ea, eb);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
